// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the Y86-64 pipeline datapath (master) and its fetch/hazard
// controller (slave).
interface fetch_ctrl_if;
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        f_instr_valid;
    logic        f_imem_error;
    logic        f_hlt;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  E_icode;
    logic [3:0]  E_dstM;
    logic [3:0]  D_icode;
    logic [3:0]  M_icode;
    logic [3:0]  W_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [63:0] W_valM;
    logic [63:0] PC;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic        E_bubble;
    logic [1:0]  stat;
    logic        done;

    modport master (
        output f_icode, f_valC, f_valP, f_instr_valid, f_imem_error, f_hlt,
               d_srcA, d_srcB, E_icode, E_dstM, D_icode, M_icode, W_icode,
               M_Cnd, M_valA, W_valM,
        input  PC, F_stall, D_stall, D_bubble, E_bubble, stat, done
    );

    modport slave (
        input  f_icode, f_valC, f_valP, f_instr_valid, f_imem_error, f_hlt,
               d_srcA, d_srcB, E_icode, E_dstM, D_icode, M_icode, W_icode,
               M_Cnd, M_valA, W_valM,
        output PC, F_stall, D_stall, D_bubble, E_bubble, stat, done
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Y86-64 fetch controller: PC selection, branch/return/load-use hazard control and
// a RUN/DRAIN/STOP sequencer that lets older instructions retire after a halt or fault.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC     = 64'd0,
    parameter int          DRAIN_CYCLES = 4      // legal range 1..7 (3-bit counter)
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  bus
);
    localparam logic [3:0] IC_JXX   = 4'h7;
    localparam logic [3:0] IC_CALL  = 4'h8;
    localparam logic [3:0] IC_RET   = 4'h9;
    localparam logic [3:0] IC_MRMOV = 4'h5;
    localparam logic [3:0] IC_POP   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_STOP} state_t;
    typedef enum logic [1:0] {STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS} stat_t;

    state_t      r_state, w_state_nxt;
    stat_t       r_stat, w_stat_nxt;
    logic [63:0] r_pred_pc, w_pred_pc_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;

    logic        w_mispredict, w_ret_pend, w_load_use, w_fault;
    logic [63:0] w_pred_fetch;
    logic        w_f_stall, w_d_stall, w_d_bubble, w_e_bubble, w_done;

    assign w_mispredict = (bus.M_icode == IC_JXX) && !bus.M_Cnd;
    assign w_ret_pend   = (bus.D_icode == IC_RET) || (bus.E_icode == IC_RET) ||
                          (bus.M_icode == IC_RET);
    assign w_load_use   = ((bus.E_icode == IC_MRMOV) || (bus.E_icode == IC_POP)) &&
                          (bus.E_dstM != REG_NONE) &&
                          ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    assign w_fault      = bus.f_imem_error || !bus.f_instr_valid || bus.f_hlt;
    assign w_pred_fetch = ((bus.f_icode == IC_JXX) || (bus.f_icode == IC_CALL)) ?
                          bus.f_valC : bus.f_valP;

    // Wrong-path recovery first, then a pending return address, then the prediction.
    assign bus.PC = w_mispredict            ? bus.M_valA :
                    (bus.W_icode == IC_RET) ? bus.W_valM : r_pred_pc;

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        w_state_nxt   = r_state;
        w_stat_nxt    = r_stat;
        w_pred_pc_nxt = r_pred_pc;
        w_cnt_nxt     = r_cnt;
        w_f_stall     = 1'b0;
        w_d_stall     = 1'b0;
        w_d_bubble    = 1'b0;
        w_e_bubble    = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            S_RUN: begin
                w_f_stall  = w_load_use | w_ret_pend;
                w_d_stall  = w_load_use & !w_mispredict;
                w_d_bubble = w_mispredict | (w_ret_pend & !w_load_use);
                w_e_bubble = w_mispredict | w_load_use;
                if (!w_f_stall) begin
                    w_pred_pc_nxt = w_pred_fetch;
                    // A fault fetched alongside a mispredict is wrong-path and ignored.
                    if (!w_mispredict && w_fault) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = DRAIN_LOAD;
                        if (bus.f_imem_error)       w_stat_nxt = STAT_ADR;
                        else if (!bus.f_instr_valid) w_stat_nxt = STAT_INS;
                        else                        w_stat_nxt = STAT_HLT;
                    end
                end
            end
            S_DRAIN: begin
                w_f_stall  = 1'b1;
                w_d_bubble = 1'b1;
                w_e_bubble = w_mispredict;
                if (w_mispredict) begin
                    w_state_nxt   = S_RUN;
                    w_stat_nxt    = STAT_AOK;
                    w_pred_pc_nxt = bus.M_valA;
                    w_cnt_nxt     = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                w_f_stall  = 1'b1;
                w_d_bubble = 1'b1;
                w_done     = 1'b1;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state   <= S_RUN;
            r_stat    <= STAT_AOK;
            r_pred_pc <= RESET_PC;
            r_cnt     <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_stat    <= w_stat_nxt;
            r_pred_pc <= w_pred_pc_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.F_stall  = w_f_stall;
    assign bus.D_stall  = w_d_stall;
    assign bus.D_bubble = w_d_bubble;
    assign bus.E_bubble = w_e_bubble;
    assign bus.stat     = r_stat;
    assign bus.done     = w_done;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each step drives pipeline inputs, pushes the expected
// controller outputs to a scoreboard, and compares them at the following falling edge.
module tb_fetch_ctrl;
    logic clk;
    logic rst;
    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] pc;
        logic        fs;
        logic        ds;
        logic        db;
        logic        eb;
        logic [1:0]  st;
        logic        dn;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string tag, input string field,
                       input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic [63:0] pc,
                              input logic fs, input logic ds, input logic db,
                              input logic eb, input logic [1:0] st, input logic dn);
        exp_t e;
        e.tag = tag; e.pc = pc; e.fs = fs; e.ds = ds; e.db = db;
        e.eb = eb; e.st = st; e.dn = dn;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty observed=0 entries expected>=1");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "PC",       bus.PC,                e.pc);
            cmp(e.tag, "F_stall",  64'(bus.F_stall),      64'(e.fs));
            cmp(e.tag, "D_stall",  64'(bus.D_stall),      64'(e.ds));
            cmp(e.tag, "D_bubble", 64'(bus.D_bubble),     64'(e.db));
            cmp(e.tag, "E_bubble", 64'(bus.E_bubble),     64'(e.eb));
            cmp(e.tag, "stat",     64'(bus.stat),         64'(e.st));
            cmp(e.tag, "done",     64'(bus.done),         64'(e.dn));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.f_icode       = 4'h1;
        bus.f_valC        = 64'd0;
        bus.f_valP        = 64'd0;
        bus.f_instr_valid = 1'b1;
        bus.f_imem_error  = 1'b0;
        bus.f_hlt         = 1'b0;
        bus.d_srcA        = 4'hF;
        bus.d_srcB        = 4'hF;
        bus.E_icode       = 4'h1;
        bus.E_dstM        = 4'hF;
        bus.D_icode       = 4'h1;
        bus.M_icode       = 4'h1;
        bus.W_icode       = 4'h1;
        bus.M_Cnd         = 1'b1;
        bus.M_valA        = 64'd0;
        bus.W_valM        = 64'd0;
    endtask

    task automatic mispredict(input logic [63:0] target);
        bus.M_icode = 4'h7;
        bus.M_Cnd   = 1'b0;
        bus.M_valA  = target;
    endtask

    initial begin
        // Reset, then sequential fall-through.
        set_idle(); bus.f_valP = 64'h1; rst = 1'b1;
        cycle(); rst = 1'b0;
        expect_out("reset", 64'h0, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();
        set_idle(); bus.f_valP = 64'h2;
        expect_out("fallthru", 64'h1, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();

        // Jump predicted taken, later found not taken.
        set_idle(); bus.f_icode = 4'h7; bus.f_valC = 64'h20; bus.f_valP = 64'h0A;
        expect_out("jxx_fetch", 64'h2, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();
        set_idle(); bus.f_valP = 64'h21;
        expect_out("jxx_pred", 64'h20, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();
        set_idle(); mispredict(64'h2B); bus.f_valP = 64'h2C;
        expect_out("mispredict", 64'h2B, 0, 0, 1, 1, 2'd0, 0); check_out(); cycle();
        set_idle(); bus.f_valP = 64'h2D;
        expect_out("after_mp", 64'h2C, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();

        // Load-use on d_srcB holds the PC for one cycle.
        set_idle(); bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcB = 4'h3; bus.f_valP = 64'h2E;
        expect_out("load_use", 64'h2D, 1, 1, 0, 1, 2'd0, 0); check_out(); cycle();
        set_idle(); bus.f_valP = 64'h2E;
        expect_out("lu_hold", 64'h2D, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();

        // Return walking D, E, M then W supplying the address.
        set_idle(); bus.D_icode = 4'h9; bus.f_valP = 64'h99;
        expect_out("ret_D", 64'h2E, 1, 0, 1, 0, 2'd0, 0); check_out(); cycle();
        set_idle(); bus.E_icode = 4'h9; bus.f_valP = 64'h99;
        expect_out("ret_E", 64'h2E, 1, 0, 1, 0, 2'd0, 0); check_out(); cycle();
        set_idle(); bus.M_icode = 4'h9; bus.f_valP = 64'h99;
        expect_out("ret_M", 64'h2E, 1, 0, 1, 0, 2'd0, 0); check_out(); cycle();
        set_idle(); bus.W_icode = 4'h9; bus.W_valM = 64'h40; bus.f_valP = 64'h41;
        expect_out("ret_W", 64'h40, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();

        // Call to 0x32, halt there, drain, stop.
        set_idle(); bus.f_icode = 4'h8; bus.f_valC = 64'h32; bus.f_valP = 64'h4A;
        expect_out("call_fetch", 64'h41, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();
        set_idle(); bus.f_icode = 4'h0; bus.f_hlt = 1'b1; bus.f_valP = 64'h33;
        expect_out("halt_fetch", 64'h32, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();
        for (int i = 0; i < 4; i++) begin
            set_idle(); bus.f_valP = 64'h70;
            expect_out($sformatf("drain%0d", i), 64'h33, 1, 0, 1, 0, 2'd1, 0);
            check_out(); cycle();
        end
        set_idle();
        expect_out("stop", 64'h33, 1, 0, 1, 0, 2'd1, 1); check_out(); cycle();
        set_idle(); mispredict(64'h55);
        expect_out("stop_mp", 64'h55, 1, 0, 1, 0, 2'd1, 1); check_out(); cycle();
        set_idle(); rst = 1'b1;
        expect_out("stop_hold", 64'h33, 1, 0, 1, 0, 2'd1, 1); check_out(); cycle();
        rst = 1'b0; set_idle(); bus.f_valP = 64'h1;
        expect_out("rst_from_stop", 64'h0, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();

        // Memory fault squashed by a mispredict while draining.
        set_idle(); bus.f_imem_error = 1'b1; bus.f_valP = 64'h2;
        expect_out("adr_fetch", 64'h1, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();
        set_idle(); mispredict(64'h10);
        expect_out("drain_mp", 64'h10, 1, 0, 1, 1, 2'd2, 0); check_out(); cycle();
        set_idle(); bus.f_valP = 64'h11;
        expect_out("squash_run", 64'h10, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();

        // Invalid instruction fetched in the mispredict cycle is ignored.
        set_idle(); bus.f_instr_valid = 1'b0; mispredict(64'h60); bus.f_valP = 64'h61;
        expect_out("ins_wrongpath", 64'h60, 0, 0, 1, 1, 2'd0, 0); check_out(); cycle();
        set_idle(); bus.f_valP = 64'h62;
        expect_out("ins_ignored", 64'h61, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();

        // Invalid instruction enters DRAIN; reset wins over a same-edge mispredict.
        set_idle(); bus.f_instr_valid = 1'b0; bus.f_valP = 64'h63;
        expect_out("ins_fetch", 64'h62, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();
        set_idle(); mispredict(64'h77); rst = 1'b1;
        expect_out("ins_drain_mp", 64'h77, 1, 0, 1, 1, 2'd3, 0); check_out(); cycle();
        rst = 1'b0;

        // Load-use together with mispredict, then a non-matching POP/none destination.
        set_idle(); bus.E_icode = 4'hB; bus.E_dstM = 4'h4; bus.d_srcA = 4'h4;
        mispredict(64'h88); bus.f_valP = 64'h89;
        expect_out("lu_and_mp", 64'h88, 1, 0, 1, 1, 2'd0, 0); check_out(); cycle();
        set_idle(); bus.E_icode = 4'h5; bus.E_dstM = 4'hF; bus.f_valP = 64'h5;
        expect_out("dst_none", 64'h0, 0, 0, 0, 0, 2'd0, 0); check_out(); cycle();
        set_idle();
        expect_out("final_pc", 64'h5, 0, 0, 0, 0, 2'd0, 0); check_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
